button_event_gen: RTL



---
 rtl/button_event_gen.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// Player-button front end: 2-flop synchroniser, per-button debounce, press events into a command FIFO.
// Optional left/right auto-repeat is built when BUTTON_AUTO_REPEAT_EN is defined.
module button_event_gen #(
  parameter int unsigned debounce_cycles_p = 8000,
  parameter int unsigned repeat_delay_p    = 2400000,
  parameter int unsigned repeat_period_p   = 800000,
  parameter int unsigned fifo_depth_p      = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [3:0] btn_i,
  output logic       cmd_v_o,
  output logic [1:0] cmd_o,
  input  logic       cmd_ready_i,
  output logic [3:0] held_o,
  output logic       overflow_o
);

  localparam int unsigned DbW   = $clog2(debounce_cycles_p + 1);
  localparam int unsigned AddrW = $clog2(fifo_depth_p);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [DbW-1:0]   DbLast   = DbW'(debounce_cycles_p - 1);
  localparam logic [DbW-1:0]   DbOne    = DbW'(1);
  localparam logic [AddrW-1:0] PtrOne   = AddrW'(1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [CntW-1:0]  FifoFull = CntW'(fifo_depth_p);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       db_q, db_d;
  logic [DbW-1:0]   db_cnt_q [4];
  logic [DbW-1:0]   db_cnt_d [4];
  logic [3:0]       held_q, held_prev_q;
  logic [3:0]       pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       mem_q [fifo_depth_p];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             cmd_v_q, cmd_v_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [3:0]       event_s, grant_s;
  logic [1:0]       push_cmd_s;
  logic             push_s, pop_s, accept_s, lost_s;

  // Debounce: a level change is accepted only after debounce_cycles_p consecutive differing samples
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      db_d[k]     = db_q[k];
      db_cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (db_cnt_q[k] == DbLast) begin
          db_d[k]     = ~db_q[k];
          db_cnt_d[k] = '0;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DbOne;
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  // Synchroniser, debounce state and the registered held levels used for edge detection
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_q     <= 4'b0000;
      sync2_q     <= 4'b0000;
      db_q        <= 4'b0000;
      held_q      <= 4'b0000;
      held_prev_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      held_q      <= db_q;
      held_prev_q <= held_q;
      for (int k = 0; k < 4; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (repeat_delay_p > repeat_period_p) ? repeat_delay_p : repeat_period_p;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] RptDelay  = RptW'(repeat_delay_p);
  localparam logic [RptW-1:0] RptPeriod = RptW'(repeat_period_p);
  localparam logic [RptW-1:0] RptOne    = RptW'(1);

  logic [RptW-1:0] rpt_cnt_q [2];
  logic [RptW-1:0] rpt_cnt_d [2];
  logic [1:0]      rpt_phase_q, rpt_phase_d, rpt_fire_s;

  // Repeat timers for left/right: first fire after the delay, then once per period while held
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rpt_cnt_d[k]   = '0;
      rpt_phase_d[k] = 1'b0;
      rpt_fire_s[k]  = 1'b0;
      if (held_q[k]) begin
        if (rpt_cnt_q[k] == (rpt_phase_q[k] ? RptPeriod : RptDelay)) begin
          rpt_fire_s[k]  = 1'b1;
          rpt_cnt_d[k]   = RptOne;
          rpt_phase_d[k] = 1'b1;
        end else begin
          rpt_cnt_d[k]   = rpt_cnt_q[k] + RptOne;
          rpt_phase_d[k] = rpt_phase_q[k];
        end
      end else begin
        rpt_cnt_d[k]   = '0;
        rpt_phase_d[k] = 1'b0;
      end
    end
  end

  // Repeat timer state
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rpt_phase_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        rpt_cnt_q[k] <= '0;
      end
    end else begin
      rpt_phase_q <= rpt_phase_d;
      for (int k = 0; k < 2; k++) begin
        rpt_cnt_q[k] <= rpt_cnt_d[k];
      end
    end
  end

  assign event_s = (held_q & ~held_prev_q) | {2'b00, rpt_fire_s};
`else
  assign event_s = held_q & ~held_prev_q;
`endif

  assign pop_s    = cmd_v_q & cmd_ready_i;
  assign accept_s = (count_q != FifoFull) | pop_s;
  assign push_s   = |grant_s;

  // Fixed-priority arbiter: start > rotate > left > right, one push per cycle
  always_comb begin
    grant_s    = 4'b0000;
    push_cmd_s = 2'd0;
    if (accept_s) begin
      if (pending_q[3]) begin
        grant_s    = 4'b1000;
        push_cmd_s = 2'd3;
      end else if (pending_q[2]) begin
        grant_s    = 4'b0100;
        push_cmd_s = 2'd2;
      end else if (pending_q[0]) begin
        grant_s    = 4'b0001;
        push_cmd_s = 2'd0;
      end else if (pending_q[1]) begin
        grant_s    = 4'b0010;
        push_cmd_s = 2'd1;
      end else begin
        grant_s    = 4'b0000;
        push_cmd_s = 2'd0;
      end
    end else begin
      grant_s    = 4'b0000;
      push_cmd_s = 2'd0;
    end
  end

  // A granted bit frees its slot, so an event on the same edge re-arms it instead of being lost
  always_comb begin
    pending_d  = (pending_q & ~grant_s) | event_s;
    lost_s     = |(event_s & pending_q & ~grant_s);
    overflow_d = overflow_q | lost_s;
  end

  // FIFO pointers and the registered head, computed from post-edge state
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PtrOne) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    cmd_v_d = (count_d != '0);
    if (count_d == '0) begin
      cmd_d = cmd_q;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      cmd_d = push_cmd_s;
    end else begin
      cmd_d = mem_q[rd_ptr_d];
    end
  end

  // Pending/overflow and FIFO state
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pending_q  <= 4'b0000;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_v_q    <= 1'b0;
      cmd_q      <= 2'd0;
      for (int i = 0; i < int'(fifo_depth_p); i++) begin
        mem_q[i] <= 2'd0;
      end
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_v_q    <= cmd_v_d;
      cmd_q      <= cmd_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_cmd_s;
      end
    end
  end

  assign cmd_v_o    = cmd_v_q;
  assign cmd_o      = cmd_q;
  assign held_o     = held_q;
  assign overflow_o = overflow_q;

endmodule
